// File: rtl/min_arb_pkg.sv
// Shared types and arbitration helpers for the min_search_arb scheduler.
package min_arb_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic client_t;

    // A lone requester wins outright; with both requesting, the client not served last wins.
    function automatic client_t rr_pick(input logic [NUM_CLIENTS-1:0] req, input client_t last);
        client_t pick;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_t c);
        logic [NUM_CLIENTS-1:0] oh;
        if (c) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/min_scan_core.sv
// Per-element min1/min2/index compare-update datapath.
// MIN_SEARCH_TIE_LAST_EN: ties on min1 move the index to the latest occurrence.
module min_scan_core
    import min_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          init,
    input  logic          en,
    input  logic [N-1:0]  d,
    input  logic [IW-1:0] k,
    output logic [N-1:0]  min1,
    output logic [N-1:0]  min2,
    output logic [IW-1:0] index
);

    logic [N-1:0]  min1_r;
    logic [N-1:0]  min2_r;
    logic [IW-1:0] index_r;
    logic [N-1:0]  min1_n_s;
    logic [N-1:0]  min2_n_s;
    logic [IW-1:0] index_n_s;
    logic          take_min1_s;

    // Decide whether the incoming element displaces the current minimum.
    always_comb begin
`ifdef MIN_SEARCH_TIE_LAST_EN
        take_min1_s = (d <= min1_r);
`else
        take_min1_s = (d < min1_r);
`endif
    end

    // Next-value selection: load element 0 on init, otherwise fold in element k.
    always_comb begin
        min1_n_s  = min1_r;
        min2_n_s  = min2_r;
        index_n_s = index_r;
        if (init) begin
            min1_n_s  = d;
            min2_n_s  = {N{1'b1}};
            index_n_s = k;
        end else if (en) begin
            if (take_min1_s) begin
                min2_n_s  = min1_r;
                min1_n_s  = d;
                index_n_s = k;
            end else if (d < min2_r) begin
                min2_n_s = d;
            end else begin
                min2_n_s = min2_r;
            end
        end else begin
            min1_n_s = min1_r;
        end
    end

    // Result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min1_r  <= {N{1'b1}};
            min2_r  <= {N{1'b1}};
            index_r <= {IW{1'b0}};
        end else begin
            min1_r  <= min1_n_s;
            min2_r  <= min2_n_s;
            index_r <= index_n_s;
        end
    end

    assign min1  = min1_r;
    assign min2  = min2_r;
    assign index = index_r;

endmodule

// File: rtl/min_search_arb.sv
// Two-client round-robin scheduler around a single min1/min2/index search engine.
// MIN_SEARCH_TIE_LAST_EN (in min_scan_core) selects latest-index tie handling.
module min_search_arb
    import min_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int M  = 10,
    parameter int IW = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [N*M-1:0]         data0_i,
    input  logic [N*M-1:0]         data1_i,
    output logic [NUM_CLIENTS-1:0] gnt_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   done_id_o,
    input  logic                   ack_i,
    output logic [N-1:0]           min1_o,
    output logic [N-1:0]           min2_o,
    output logic [IW-1:0]          index_o
);

    state_t                 state_r;
    state_t                 state_n_s;
    logic [IW-1:0]          k_r;
    logic [IW-1:0]          k_n_s;
    client_t                last_r;
    client_t                last_n_s;
    client_t                sel_s;
    client_t                done_id_r;
    logic                   done_r;
    logic                   busy_r;
    logic                   init_s;
    logic                   en_s;
    logic [NUM_CLIENTS-1:0] gnt_s;
    logic [N*M-1:0]         sel_frame_s;
    logic [N-1:0]           frame_r [M];
    logic [N-1:0]           core_d_s;
    logic [IW-1:0]          core_k_s;

    // Arbitration choice and the frame of the client that would be granted.
    always_comb begin
        sel_s = rr_pick(req_i, last_r);
        if (sel_s) begin
            sel_frame_s = data1_i;
        end else begin
            sel_frame_s = data0_i;
        end
    end

    // FSM next-state, grant pulse and datapath strobes.
    always_comb begin
        state_n_s = state_r;
        k_n_s     = k_r;
        last_n_s  = last_r;
        init_s    = 1'b0;
        en_s      = 1'b0;
        gnt_s     = {NUM_CLIENTS{1'b0}};
        case (state_r)
            IDLE: begin
                if (|req_i) begin
                    gnt_s     = client_onehot(sel_s);
                    init_s    = 1'b1;
                    k_n_s     = IW'(1);
                    last_n_s  = sel_s;
                    state_n_s = (M > 1) ? SCAN : DONE;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SCAN: begin
                en_s  = 1'b1;
                k_n_s = k_r + IW'(1);
                if (k_r == IW'(M - 1)) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = SCAN;
                end
            end
            DONE: begin
                if (ack_i) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Element 0 comes straight from the client bus because the frame is captured on the same edge.
    always_comb begin
        if (init_s) begin
            core_d_s = sel_frame_s[N-1:0];
            core_k_s = {IW{1'b0}};
        end else begin
            core_d_s = frame_r[k_r];
            core_k_s = k_r;
        end
    end

    // Control state, round-robin pointer and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            k_r       <= {IW{1'b0}};
            last_r    <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_id_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            k_r     <= k_n_s;
            last_r  <= last_n_s;
            done_r  <= (state_n_s == DONE);
            busy_r  <= (state_n_s != IDLE);
            if (init_s) begin
                done_id_r <= sel_s;
            end
        end
    end

    // Frame buffer, loaded only in the grant cycle.
    always_ff @(posedge clk_i) begin
        if (init_s) begin
            for (int e = 0; e < M; e++) begin
                frame_r[e] <= sel_frame_s[e*N +: N];
            end
        end
    end

    min_scan_core #(
        .N  (N),
        .IW (IW)
    ) u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .init  (init_s),
        .en    (en_s),
        .d     (core_d_s),
        .k     (core_k_s),
        .min1  (min1_o),
        .min2  (min2_o),
        .index (index_o)
    );

    assign gnt_o     = gnt_s;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign done_id_o = done_id_r;

endmodule

// File: tb/tb_min_search_arb.sv
// Scoreboard bench for min_search_arb: a driver pushes model results, a monitor checks and acknowledges.
module tb_min_search_arb;

    localparam int N  = 4;
    localparam int M  = 10;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [1:0]     req_i;
    logic [N*M-1:0] data0_i;
    logic [N*M-1:0] data1_i;
    logic [1:0]     gnt_o;
    logic           busy_o;
    logic           done_o;
    logic           done_id_o;
    logic           ack_i;
    logic [N-1:0]   min1_o;
    logic [N-1:0]   min2_o;
    logic [IW-1:0]  index_o;

    typedef struct {
        int client;
        int m1;
        int m2;
        int ix;
        int gcyc;
        int ack_delay;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    bit   mon_busy = 1'b0;
    int   mlast    = 1;
    int   f0[M];
    int   f1[M];

    min_search_arb #(.N(N), .M(M), .IW(IW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .data0_i   (data0_i),
        .data1_i   (data1_i),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .done_id_o (done_id_o),
        .ack_i     (ack_i),
        .min1_o    (min1_o),
        .min2_o    (min2_o),
        .index_o   (index_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: min1 is the frame minimum, index its first (or last) position,
    // min2 the minimum of the remaining elements as a multiset.
    function automatic void ref_search(input int v[M], output int m1, output int m2, output int ix);
        m1 = v[0];
        for (int i = 1; i < M; i++) if (v[i] < m1) m1 = v[i];
        ix = -1;
        for (int i = 0; i < M; i++) begin
`ifdef MIN_SEARCH_TIE_LAST_EN
            if (v[i] == m1) ix = i;
`else
            if (v[i] == m1 && ix < 0) ix = i;
`endif
        end
        m2 = (1 << N) - 1;
        for (int i = 0; i < M; i++) if (i != ix && v[i] < m2) m2 = v[i];
    endfunction

    task automatic randomize_frames();
        for (int i = 0; i < M; i++) begin
            f0[i] = int'($urandom_range(0, (1 << N) - 1));
            f1[i] = int'($urandom_range(0, (1 << N) - 1));
        end
    endtask

    task automatic issue(input logic [1:0] req, input int ack_delay, input bit push,
                         input bit keep_req, output int gcyc);
        bit   got;
        int   w;
        exp_t e;
        got = 1'b0;
        @(posedge clk); #1;
        req_i = req;
        for (int i = 0; i < M; i++) begin
            data0_i[i*N +: N] = N'(f0[i]);
            data1_i[i*N +: N] = N'(f1[i]);
        end
        for (int c = 0; c < 200; c++) begin
            #1;
            if (gnt_o !== 2'b00) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        gcyc = cyc;
        if (!got) begin
            check("grant_timeout", 32'd0, 32'd1);
        end else begin
            if (req == 2'b01) w = 0;
            else if (req == 2'b10) w = 1;
            else w = (mlast == 1) ? 0 : 1;
            check("gnt", {30'd0, gnt_o}, (w == 0) ? 32'd1 : 32'd2);
            mlast = w;
            if (push) begin
                if (w == 0) ref_search(f0, e.m1, e.m2, e.ix);
                else        ref_search(f1, e.m1, e.m2, e.ix);
                e.client    = w;
                e.gcyc      = cyc;
                e.ack_delay = ack_delay;
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (!keep_req) req_i = 2'b00;
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !mon_busy) break;
            @(posedge clk); #1;
        end
        check("drain", exp_q.size() + int'(mon_busy), 32'd0);
    endtask

    // Monitor: checks results whenever done_o is presented, holds ack for the requested delay.
    initial begin
        exp_t e;
        ack_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc - e.gcyc, M);
                    check("done_id", {31'd0, done_id_o}, e.client);
                    check("min1", {28'd0, min1_o}, e.m1);
                    check("min2", {28'd0, min2_o}, e.m2);
                    check("index", {28'd0, index_o}, e.ix);
                    for (int i = 0; i < e.ack_delay; i++) begin
                        @(posedge clk); #1;
                        check("hold_done", {31'd0, done_o}, 32'd1);
                        check("hold_min1", {28'd0, min1_o}, e.m1);
                        check("hold_min2", {28'd0, min2_o}, e.m2);
                        check("hold_index", {28'd0, index_o}, e.ix);
                        check("hold_no_gnt", {30'd0, gnt_o}, 32'd0);
                    end
                end
                ack_i = 1'b1;
                @(posedge clk); #1;
                ack_i = 1'b0;
                check("done_fall", {31'd0, done_o}, 32'd0);
                check("idle_after_ack", {31'd0, busy_o}, 32'd0);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int g;
        int g_prev;
        rst_i   = 1'b1;
        req_i   = 2'b00;
        data0_i = '0;
        data1_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("rst_gnt", {30'd0, gnt_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_done_id", {31'd0, done_id_o}, 32'd0);
        check("rst_min1", {28'd0, min1_o}, 32'd15);
        check("rst_min2", {28'd0, min2_o}, 32'd15);
        check("rst_index", {28'd0, index_o}, 32'd0);

        // Single client frame from the plan.
        f0 = '{7, 3, 9, 3, 1, 8, 2, 5, 6, 4};
        issue(2'b01, 0, 1'b1, 1'b0, g);
        drain();

        // Duplicate minimum through client 1.
        f1 = '{5, 2, 9, 2, 6, 7, 8, 9, 9, 9};
        issue(2'b10, 0, 1'b1, 1'b0, g);
        drain();

        // All-ones frame.
        for (int i = 0; i < M; i++) f0[i] = 15;
        issue(2'b01, 0, 1'b1, 1'b0, g);
        drain();

        // Ack backpressure with a competing request pending during DONE.
        randomize_frames();
        issue(2'b01, 5, 1'b1, 1'b0, g_prev);
        randomize_frames();
        issue(2'b10, 0, 1'b1, 1'b0, g);
        check("backpressure_gap", g - g_prev, M + 1 + 5);
        drain();

        // Both clients requesting continuously with immediate ack.
        randomize_frames();
        g_prev = 0;
        for (int i = 0; i < 6; i++) begin
            issue(2'b11, 0, 1'b1, 1'b1, g);
            if (i > 0) check("rr_gap", g - g_prev, M + 1);
            g_prev = g;
            randomize_frames();
        end
        req_i = 2'b00;
        drain();

        // Reset during SCAN, after a client-0 grant left the pointer at 0.
        randomize_frames();
        issue(2'b01, 0, 1'b1, 1'b0, g);
        drain();
        randomize_frames();
        issue(2'b01, 0, 1'b0, 1'b0, g);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        mlast = 1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_done", {31'd0, done_o}, 32'd0);
        check("midrst_min1", {28'd0, min1_o}, 32'd15);
        check("midrst_min2", {28'd0, min2_o}, 32'd15);
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_done", {31'd0, done_o}, 32'd0);
        randomize_frames();
        issue(2'b11, 0, 1'b1, 1'b0, g);
        drain();
        randomize_frames();
        issue(2'b10, 0, 1'b1, 1'b0, g);
        drain();

        // Randomized mix of request patterns and ack delays.
        for (int i = 0; i < 20; i++) begin
            randomize_frames();
            issue(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b1, 1'b0, g);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
